// File: rtl/mult_pkg.sv
// Shared types, defaults and parity helper for the parity-protected multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_ERR_CNT_W = 16;

  // calc_parity works on a fixed-width vector; narrower values are zero-extended,
  // which leaves their XOR unchanged. Supports products up to 128 bits (WIDTH <= 64).
  localparam int PAR_VEC_W = 128;

  // Operand packet of the 16-bit configuration.
  typedef struct packed {
    logic [15:0] a;
    logic        a_parity;
    logic [15:0] b;
    logic        b_parity;
  } t_data_packet;

  // Result vector of the 16-bit configuration.
  typedef struct packed {
    logic [31:0] mult_res;
    logic        par_error;
    logic        result_par;
  } t_s_output_vect;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [PAR_VEC_W-1:0] value, input logic odd);
    return (^value) ^ odd;
  endfunction

endpackage

// File: rtl/mult_pipe_reg.sv
// One pipeline stage: valid bit plus generic payload, loaded when en is high.
// Latency: 1 cycle when enabled.
// Backpressure: en low freezes both valid and payload (global stall).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears the valid bit only)
//   en               stage advance
//   d_valid, d_data  incoming stage contents
//   q_valid, q_data  registered stage contents
module mult_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid;
    end
  end

  // Payload is qualified by q_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/mult_par_pipe.sv
// Pipelined signed multiplier with operand parity check and saturating error counter.
// Latency: LATENCY cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: whole pipe stalls when out_valid && !out_ready; in_ready follows.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          operand handshake
//   arg_a/arg_a_parity         operand A and its parity bit
//   arg_b/arg_b_parity         operand B and its parity bit
//   out_valid/out_ready        result handshake
//   mult_res                   signed product, 0 on parity error
//   par_error                  operand parity error flag
//   result_par                 parity of mult_res
//   err_cnt/clr_err            saturating count of bad accepted packets, sync clear
module mult_par_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int PARITY_ODD = 0,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       arg_a,
  input  logic                   arg_a_parity,
  input  logic [WIDTH-1:0]       arg_b,
  input  logic                   arg_b_parity,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     mult_res,
  output logic                   par_error,
  output logic                   result_par,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  input  logic                   clr_err
);

  localparam int   RES_W = 2 * WIDTH;
  localparam int   PAY_W = RES_W + 2;
  localparam logic ODD   = (PARITY_ODD != 0);

  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Stage-1 logic: parity check, product, result parity.
  logic [PAR_VEC_W-1:0]    a_vec;
  logic [PAR_VEC_W-1:0]    b_vec;
  logic [PAR_VEC_W-1:0]    res_vec;
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] prod;
  logic [RES_W-1:0]        res_s1;
  logic                    err_s1;
  logic                    rpar_s1;

  // Sign-extending to 2*WIDTH first makes the truncated product exact,
  // including (-2^(WIDTH-1))^2.
  assign a_ext = {{WIDTH{arg_a[WIDTH-1]}}, arg_a};
  assign b_ext = {{WIDTH{arg_b[WIDTH-1]}}, arg_b};
  assign prod  = a_ext * b_ext;

  always_comb begin
    a_vec              = '0;
    b_vec              = '0;
    a_vec[WIDTH-1:0]   = arg_a;
    b_vec[WIDTH-1:0]   = arg_b;
    err_s1 = (arg_a_parity != calc_parity(a_vec, ODD)) ||
             (arg_b_parity != calc_parity(b_vec, ODD));
    res_s1             = err_s1 ? '0 : prod;
    res_vec            = '0;
    res_vec[RES_W-1:0] = res_s1;
    // A zeroed result naturally yields parity == ODD.
    rpar_s1            = calc_parity(res_vec, ODD);
  end

  // Stage chain: index 0 is the combinational input, LATENCY is the output stage.
  logic [LATENCY:0]            stg_vld;
  logic [LATENCY:0][PAY_W-1:0] stg_dat;

  assign stg_vld[0] = in_valid;
  assign stg_dat[0] = {err_s1, rpar_s1, res_s1};

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    mult_pipe_reg #(.W(PAY_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .d_valid (stg_vld[i]),
      .d_data  (stg_dat[i]),
      .q_valid (stg_vld[i+1]),
      .q_data  (stg_dat[i+1])
    );
  end

  // Output data is masked by valid so the reset-state outputs are defined
  // without resetting the payload registers.
  logic [PAY_W-1:0] last;
  assign last       = stg_dat[LATENCY];
  assign out_valid  = stg_vld[LATENCY];
  assign mult_res   = out_valid ? last[RES_W-1:0] : '0;
  assign par_error  = out_valid && last[PAY_W-1];
  assign result_par = out_valid ? last[PAY_W-2] : ODD;

  // Counted at acceptance; clear wins over increment; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_cnt <= '0;
    end else if (accept && err_s1 && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_par_pipe.sv
module tb_mult_par_pipe;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // d0: WIDTH=16, LATENCY=2, even parity, 16-bit counter
  logic        d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_clr_err;
  logic [15:0] d0_arg_a, d0_arg_b, d0_err_cnt;
  logic        d0_arg_a_parity, d0_arg_b_parity, d0_par_error, d0_result_par;
  logic [31:0] d0_mult_res;

  // d1: WIDTH=8, LATENCY=4, odd parity, 2-bit counter
  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_clr_err;
  logic [7:0]  d1_arg_a, d1_arg_b;
  logic [1:0]  d1_err_cnt;
  logic        d1_arg_a_parity, d1_arg_b_parity, d1_par_error, d1_result_par;
  logic [15:0] d1_mult_res;

  mult_par_pipe #(.WIDTH(16), .LATENCY(2), .PARITY_ODD(0), .ERR_CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .arg_a(d0_arg_a), .arg_a_parity(d0_arg_a_parity),
    .arg_b(d0_arg_b), .arg_b_parity(d0_arg_b_parity),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .mult_res(d0_mult_res),
    .par_error(d0_par_error), .result_par(d0_result_par),
    .err_cnt(d0_err_cnt), .clr_err(d0_clr_err)
  );

  mult_par_pipe #(.WIDTH(8), .LATENCY(4), .PARITY_ODD(1), .ERR_CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .arg_a(d1_arg_a), .arg_a_parity(d1_arg_a_parity),
    .arg_b(d1_arg_b), .arg_b_parity(d1_arg_b_parity),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .mult_res(d1_mult_res),
    .par_error(d1_par_error), .result_par(d1_result_par),
    .err_cnt(d1_err_cnt), .clr_err(d1_clr_err)
  );

  // Scoreboards
  t_s_output_vect q0[$];
  logic [17:0]    q1[$];   // {mult_res, par_error, result_par}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic t_data_packet pk(input logic [15:0] a, input logic ap,
                                      input logic [15:0] b, input logic bp);
    t_data_packet p;
    p.a = a; p.a_parity = ap; p.b = b; p.b_parity = bp;
    return p;
  endfunction

  function automatic t_s_output_vect ov(input logic [31:0] r, input logic e, input logic p);
    t_s_output_vect v;
    v.mult_res = r; v.par_error = e; v.result_par = p;
    return v;
  endfunction

  // Monitors: compare whenever a result is presented; while stalled, the held
  // value must still match the head of the queue.
  always @(negedge clk) begin
    if (!rst && d0_out_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected: got result 0x%0h expected no output at %0t", d0_mult_res, $time);
      end else begin
        chk("d0_result", 64'({d0_mult_res, d0_par_error, d0_result_par}), 64'(q0[0]));
        if (d0_out_ready) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d1_out_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected: got result 0x%0h expected no output at %0t", d1_mult_res, $time);
      end else begin
        chk("d1_result", 64'({d1_mult_res, d1_par_error, d1_result_par}), 64'(q1[0]));
        if (d1_out_ready) void'(q1.pop_front());
      end
    end
  end

  // Drive a packet, wait (bounded) for acceptance, push the expectation on accept.
  // Returns 1 time unit after the accepting edge.
  task automatic issue0(input t_data_packet p, input t_s_output_vect e);
    bit accepted = 0;
    d0_in_valid = 1'b1;
    d0_arg_a = p.a; d0_arg_a_parity = p.a_parity;
    d0_arg_b = p.b; d0_arg_b_parity = p.b_parity;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (d0_in_ready) begin
        q0.push_back(e);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    d0_in_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL d0_accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic issue1(input logic [7:0] a, input logic ap, input logic [7:0] b,
                        input logic bp, input logic [17:0] e);
    bit accepted = 0;
    d1_in_valid = 1'b1;
    d1_arg_a = a; d1_arg_a_parity = ap;
    d1_arg_b = b; d1_arg_b_parity = bp;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (d1_in_ready) begin
        q1.push_back(e);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    d1_in_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL d1_accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic drain(input int which);
    for (int n = 0; n < 60 && ((which == 0) ? q0.size() : q1.size()) != 0; n++) @(posedge clk);
    #1;
    if (which == 0) chk("d0_drain_pending", 64'(q0.size()), 64'd0);
    else            chk("d1_drain_pending", 64'(q1.size()), 64'd0);
  endtask

  t_data_packet   s_in[6];
  t_s_output_vect s_exp[6];
  int             bad_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d0_in_valid = 0; d0_out_ready = 1; d0_clr_err = 0;
    d0_arg_a = 0; d0_arg_b = 0; d0_arg_a_parity = 0; d0_arg_b_parity = 0;
    d1_in_valid = 0; d1_out_ready = 1; d1_clr_err = 0;
    d1_arg_a = 0; d1_arg_b = 0; d1_arg_a_parity = 0; d1_arg_b_parity = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out_valid",  64'(d0_out_valid),  64'd0);
    chk("rst_mult_res",   64'(d0_mult_res),   64'd0);
    chk("rst_par_error",  64'(d0_par_error),  64'd0);
    chk("rst_result_par", 64'(d0_result_par), 64'd0);
    chk("rst_err_cnt",    64'(d0_err_cnt),    64'd0);
    chk("rst_in_ready",   64'(d0_in_ready),   64'd1);
    chk("rst_d1_result_par", 64'(d1_result_par), 64'd1);
    chk("rst_d1_out_valid",  64'(d1_out_valid),  64'd0);
    rst = 1'b0;

    // 1: 3 * -2, with latency check
    issue0(pk(16'd3, 1'b0, 16'hFFFE, 1'b1), ov(32'hFFFF_FFFA, 1'b0, 1'b0));
    chk("t1_valid_after_1", 64'(d0_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid_after_2", 64'(d0_out_valid), 64'd1);
    drain(0);

    // 2: min * min
    issue0(pk(16'h8000, 1'b1, 16'h8000, 1'b1), ov(32'h4000_0000, 1'b0, 1'b1));
    drain(0);

    // 3: bad parity on A, counter moves at accept
    chk("t3_err_cnt_before", 64'(d0_err_cnt), 64'd0);
    issue0(pk(16'd5, 1'b1, 16'd7, 1'b1), ov(32'h0, 1'b1, 1'b0));
    chk("t3_err_cnt_after", 64'(d0_err_cnt), 64'd1);
    drain(0);

    // 4: six back-to-back packets with a 3-cycle output stall
    s_in[0] = pk(16'd1,     1'b1, 16'd1,     1'b1); s_exp[0] = ov(32'h0000_0001, 1'b0, 1'b1);
    s_in[1] = pk(16'd2,     1'b1, 16'd3,     1'b0); s_exp[1] = ov(32'h0000_0006, 1'b0, 1'b0);
    s_in[2] = pk(16'hFFFF,  1'b0, 16'hFFFF,  1'b0); s_exp[2] = ov(32'h0000_0001, 1'b0, 1'b1);
    s_in[3] = pk(16'h7FFF,  1'b1, 16'd2,     1'b1); s_exp[3] = ov(32'h0000_FFFE, 1'b0, 1'b1);
    s_in[4] = pk(16'hFFFD,  1'b1, 16'd4,     1'b1); s_exp[4] = ov(32'hFFFF_FFF4, 1'b0, 1'b1);
    s_in[5] = pk(16'd10,    1'b0, 16'd0,     1'b0); s_exp[5] = ov(32'h0000_0000, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) issue0(s_in[i], s_exp[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 d0_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t4_in_ready_stalled", 64'(d0_in_ready), 64'd0);
        end
        @(posedge clk);
        #1 d0_out_ready = 1'b1;
      end
    join
    drain(0);

    // 5: reset with two packets in flight (second one bad)
    issue0(pk(16'd2, 1'b1, 16'd2, 1'b1), ov(32'h4, 1'b0, 1'b1));
    issue0(pk(16'd1, 1'b0, 16'd1, 1'b1), ov(32'h0, 1'b1, 1'b0));
    chk("t5_err_cnt_pre", 64'(d0_err_cnt), 64'd2);
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    chk("t5_out_valid_rst", 64'(d0_out_valid), 64'd0);
    chk("t5_err_cnt_rst",   64'(d0_err_cnt),   64'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_late_output", 64'(d0_out_valid), 64'd0);

    // 6: 2-bit counter saturation and clear priority (odd parity, 8-bit)
    for (int i = 0; i < 5; i++) begin
      issue1(8'd1, 1'b1, 8'd1, 1'b0, {16'h0, 1'b1, 1'b1});
      chk("t6_err_cnt", 64'(d1_err_cnt), 64'(bad_exp[i]));
    end
    d1_clr_err = 1'b1;
    issue1(8'd1, 1'b1, 8'd1, 1'b0, {16'h0, 1'b1, 1'b1});
    d1_clr_err = 1'b0;
    chk("t6_err_cnt_clr", 64'(d1_err_cnt), 64'd0);
    drain(1);

    // 6b: odd-parity product with 4-cycle latency
    issue1(8'd1, 1'b0, 8'd1, 1'b0, {16'h0001, 1'b0, 1'b0});
    for (int k = 1; k < 4; k++) begin
      chk("t6_latency_not_yet", 64'(d1_out_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk("t6_latency_valid", 64'(d1_out_valid), 64'd1);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
